// File: rtl/pipelined_rca_adder.sv
// ---------------------------------------------------------------------------
// pipelined_rca_adder
//   Pipelined ripple-carry adder/subtractor. The WIDTH-bit add is cut into
//   STAGES chunks of CHUNK bits. Each stage ripples one chunk and registers
//   its carry-out for the next stage, so the critical path is one CHUNK-bit
//   ripple. The whole pipeline advances or stalls together, under a
//   valid/ready handshake on each side.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  pipeline depth (>= 1); latency is exactly STAGES cycles
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready = out_ready | ~out_valid
//   A, B                  operands
//   C                     carry-in, add mode only
//   sub                   0: Sum = A+B+C   1: Sum = A-B (A + ~B + 1)
//   out_valid / out_ready result handshake
//   Sum                   result modulo 2^WIDTH
//   finalCarry            carry out of the MSB (sub: 1 = no borrow)
//   overflow              signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------
module pipelined_rca_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             finalCarry,
    output logic             overflow
);
    localparam int CHUNK = WIDTH / STAGES;
    // Bits already summed when the last stage runs.
    localparam int LO    = (STAGES - 1) * CHUNK;

    logic             w_adv;
    logic             w_cin0;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cout_nxt;
    logic             w_ovf_nxt;
    logic             w_vld_nxt;

    // One global advance: a bubble at the output never blocks the pipe.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    // Subtraction is A + ~B + 1; C is ignored in that mode.
    assign w_b_eff = sub ? ~B : B;
    assign w_cin0  = sub | C;

    if (STAGES == 1) begin : g_one
        assign {w_cout_nxt, w_sum_nxt} = {1'b0, A} + {1'b0, w_b_eff}
                                       + {{WIDTH{1'b0}}, w_cin0};
        // Carry into the MSB recovered from the MSB sum bit.
        assign w_ovf_nxt = w_cout_nxt ^ (A[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum_nxt[WIDTH-1]);
        assign w_vld_nxt = in_valid;
    end else begin : g_pipe
        // Boundary k (1..STAGES-1) sits in front of stage k.
        // r_x holds finished sum chunks below chunk k and untouched A chunks
        // from chunk k up; each stage overwrites its own chunk in place.
        logic [STAGES-1:1][WIDTH-1:0] r_x;
        logic [STAGES-1:1][WIDTH-1:0] r_b;
        logic [STAGES-1:1]            r_c;
        logic [STAGES-1:1]            r_vld_pipe;
        logic [STAGES-1:0][CHUNK-1:0] w_s;
        logic [STAGES-1:0]            w_c;
        logic                         w_unused;

        for (genvar k = 0; k < STAGES; k++) begin : g_stg
            logic [CHUNK-1:0] w_ca;
            logic [CHUNK-1:0] w_cb;
            logic             w_ci;
            if (k == 0) begin : g_in
                assign w_ca = A[CHUNK-1:0];
                assign w_cb = w_b_eff[CHUNK-1:0];
                assign w_ci = w_cin0;
            end else begin : g_in
                assign w_ca = r_x[k][k*CHUNK +: CHUNK];
                assign w_cb = r_b[k][k*CHUNK +: CHUNK];
                assign w_ci = r_c[k];
            end
            assign {w_c[k], w_s[k]} = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, w_ci};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld_pipe <= '0;
            end else if (w_adv) begin
                r_vld_pipe[1] <= in_valid;
                for (int k = 1; k < STAGES - 1; k++) r_vld_pipe[k+1] <= r_vld_pipe[k];
            end
        end

        // Data path needs no reset: nothing downstream trusts it without a valid bit.
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_x[1] <= {A[WIDTH-1:CHUNK], w_s[0]};
                r_b[1] <= w_b_eff;
                r_c[1] <= w_c[0];
                for (int k = 1; k < STAGES - 1; k++) begin
                    r_x[k+1]                   <= r_x[k];
                    r_x[k+1][k*CHUNK +: CHUNK] <= w_s[k];
                    r_b[k+1]                   <= r_b[k];
                    r_c[k+1]                   <= w_c[k];
                end
            end
        end

        assign w_sum_nxt  = {w_s[STAGES-1], r_x[STAGES-1][LO-1:0]};
        assign w_cout_nxt = w_c[STAGES-1];
        assign w_ovf_nxt  = w_c[STAGES-1] ^ (r_x[STAGES-1][WIDTH-1] ^ r_b[STAGES-1][WIDTH-1]
                                             ^ w_s[STAGES-1][CHUNK-1]);
        assign w_vld_nxt  = r_vld_pipe[STAGES-1];
        // Low chunks of B are consumed by the time the last stage runs.
        assign w_unused   = ^r_b[STAGES-1][LO-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            Sum        <= '0;
            finalCarry <= 1'b0;
            overflow   <= 1'b0;
        end else if (w_adv) begin
            out_valid  <= w_vld_nxt;
            Sum        <= w_sum_nxt;
            finalCarry <= w_cout_nxt;
            overflow   <= w_ovf_nxt;
        end
    end
endmodule
